// File: rtl/spi_pkg.sv
// Shared types for the SPI slave receive path.
//   SPI_DATA_W : width of one SPI frame in bits
//   spi_byte_t : one received frame (slave data, FIFO entries, consumer data)
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;

    typedef logic [SPI_DATA_W-1:0] spi_byte_t;

endpackage

// File: rtl/spi_done_sync.sv
// Multi-flop synchroniser with a rising-edge detector. It brings a slave-side
// status level into the system clock domain and emits one pulse per rising edge.
//   clk        : destination clock
//   rst        : asynchronous active-low reset
//   async_in   : level from another clock domain
//   sync_out   : synchronised level (last synchroniser stage)
//   rise_pulse : one-cycle pulse on each rising edge of sync_out
module spi_done_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_out   = r_sync[SYNC_STAGES-1];
    // r_hist clears on reset. A level that is already high at reset release
    // therefore yields one fresh capture.
    assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/spi_rx_buffer.sv
// Receive buffer behind the SPI slave. Frame completions (rx_done rising) are
// synchronised into clk and push rx_data into a first-word-fall-through FIFO,
// which a consumer drains over a valid/ready interface.
//   clk, rst      : system clock, asynchronous active-low reset
//   rx_data       : byte from the slave, stable from rx_done rise to next frame
//   rx_done       : asynchronous frame-complete level
//   m_data        : head-of-FIFO byte (00 when empty)
//   m_valid       : FIFO non-empty
//   m_ready       : consumer accepts m_data this cycle
//   count         : bytes buffered, 0..DEPTH
//   full          : count == DEPTH
//   overflow      : sticky, a frame was dropped while full
//   clr_overflow  : synchronous clear of overflow (a same-cycle set wins)
module spi_rx_buffer
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  spi_byte_t               rx_data,
    input  logic                    rx_done,
    output spi_byte_t               m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    overflow,
    input  logic                    clr_overflow
);

    localparam int unsigned   AW         = $clog2(DEPTH);
    localparam logic [AW:0]   LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

    spi_byte_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic w_done_lvl;
    logic w_done_rise;
    logic w_cap;
    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    spi_done_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_done_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (rx_done),
        .sync_out   (w_done_lvl),
        .rise_pulse (w_done_rise)
    );

    // rise_pulse already implies the level is high. The AND is redundant but
    // keeps the level output connected.
    assign w_cap   = w_done_rise & w_done_lvl;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == LP_DEPTH);
    assign w_pop   = w_valid & m_ready;
    // A pop in the same cycle frees a slot, so a capture while full still lands.
    assign w_wr    = w_cap & (~w_full | w_pop);
    assign w_drop  = w_cap & w_full & ~w_pop;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign m_data   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign m_valid  = w_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Self-checking bench for spi_rx_buffer. A queue-based reference model predicts
// FIFO contents from the capture rule. A capture happens SYNC_STAGES edges after
// the first edge that samples rx_done high following a low sample.
`timescale 1ns/1ps
module tb_spi_rx_buffer;
    import spi_pkg::*;

    localparam int unsigned DEPTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic                   clk          = 1'b0;
    logic                   rst          = 1'b0;
    spi_byte_t              rx_data      = '0;
    logic                   rx_done      = 1'b0;
    logic                   m_ready      = 1'b0;
    logic                   clr_overflow = 1'b0;
    spi_byte_t              m_data;
    logic                   m_valid;
    logic                   full;
    logic                   overflow;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_rx_buffer #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of buffered bytes, sticky overflow flag, and a log
    // of the rx_done values sampled at the most recent clock edges.
    spi_byte_t            mq[$];
    bit                   m_ovf = 1'b0;
    bit [SYNC_STAGES:0]   smp   = '0;   // smp[k] = rx_done sampled k+1 edges ago

    initial forever begin
        bit pop, cap, was_full;
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
            smp   = '0;
        end else begin
            pop      = (mq.size() > 0) && (m_ready === 1'b1);
            cap      = smp[SYNC_STAGES-1] && !smp[SYNC_STAGES];
            was_full = (mq.size() == DEPTH);
            smp      = {smp[SYNC_STAGES-1:0], rx_done};
            if (pop) void'(mq.pop_front());
            if (clr_overflow) m_ovf = 1'b0;
            if (cap) begin
                if (!was_full || pop) mq.push_back(rx_data);
                else m_ovf = 1'b1;
            end
        end
    end

    // Every cycle, compare all outputs against the model, away from the edge.
    initial forever begin
        @(negedge clk);
        chk("count",    32'(count),    32'(mq.size()));
        chk("m_valid",  32'(m_valid),  32'(mq.size() != 0));
        chk("full",     32'(full),     32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("m_data",   32'(m_data),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input spi_byte_t d);
        rx_data = d;
        rx_done = 1'b1;
        tick(3);
        rx_done = 1'b0;
        tick(3);
    endtask

    task automatic drain_expect(input spi_byte_t first, input int n);
        for (int i = 0; i < n; i++) begin
            chk("drain_data", 32'(m_data), 32'(spi_byte_t'(first + i)));
            m_ready = 1'b1;
            tick(1);
            m_ready = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_valid",    32'(m_valid),  32'd0);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_mdata",    32'(m_data),   32'd0);
        rst = 1'b1;
        tick(2);

        // Single frame: latency of 3 edges counting the first sampling edge
        rx_data = 8'hA5;
        rx_done = 1'b1;
        tick(1);
        chk("lat_e0", 32'(m_valid), 32'd0);
        tick(1);
        chk("lat_e1", 32'(m_valid), 32'd0);
        tick(1);
        chk("lat_e2_valid", 32'(m_valid), 32'd1);
        chk("lat_e2_data",  32'(m_data),  32'hA5);
        chk("lat_e2_count", 32'(count),   32'd1);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        chk("pop1_valid", 32'(m_valid), 32'd0);
        chk("pop1_count", 32'(count),   32'd0);
        rx_done = 1'b0;
        tick(3);

        // Held level gives one capture only
        rx_data = 8'h3C;
        rx_done = 1'b1;
        tick(20);
        chk("held_count", 32'(count), 32'd1);
        rx_done = 1'b0;
        tick(3);
        chk("held_fall_count", 32'(count), 32'd1);
        frame(8'h3D);
        chk("held_rerise_count", 32'(count), 32'd2);
        drain_expect(8'h3C, 2);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) frame(spi_byte_t'(i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd8);
        frame(8'hFF);
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count),    32'd8);
        drain_expect(8'h01, 8);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Pointer wrap-around
        for (int i = 0; i < 5; i++) frame(spi_byte_t'(8'h20 + i));
        drain_expect(8'h20, 5);
        for (int i = 0; i < 6; i++) frame(spi_byte_t'(8'h10 + i));
        drain_expect(8'h10, 6);
        chk("wrap_count", 32'(count), 32'd0);

        // Full with capture and pop on the same edge
        for (int i = 1; i <= 8; i++) frame(spi_byte_t'(i));
        rx_data = 8'h09;
        rx_done = 1'b1;
        tick(2);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        chk("simul_count",    32'(count),    32'd8);
        chk("simul_overflow", 32'(overflow), 32'd0);
        rx_done = 1'b0;
        tick(3);
        drain_expect(8'h02, 8);

        // Asynchronous reset mid-operation, rx_done still high at release
        for (int i = 1; i <= 8; i++) frame(spi_byte_t'(i));
        frame(8'hFF);
        drain_expect(8'h01, 5);
        chk("pre_rst_count",    32'(count),    32'd3);
        chk("pre_rst_overflow", 32'(overflow), 32'd1);
        rx_data = 8'h5A;
        rx_done = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_count",    32'(count),    32'd0);
        chk("arst_valid",    32'(m_valid),  32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(8);
        chk("post_rst_count", 32'(count),  32'd1);
        chk("post_rst_data",  32'(m_data), 32'h5A);
        rx_done = 1'b0;
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(3);

        // Randomised traffic, slow then fast consumer
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                if (!rx_done) rx_data = spi_byte_t'($urandom);
                rx_done = ~rx_done;
            end
            m_ready      = ($urandom_range(0, 99) < ((c < 2000) ? 20 : 60));
            clr_overflow = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        rx_done      = 1'b0;
        m_ready      = 1'b0;
        clr_overflow = 1'b0;
        tick(4);

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_rx_buffer.md
Name: spi_rx_buffer

Overview:
Downstream stage of the SPI slave path. Takes the slave's received byte and its done flag, and synchronises done into the system clock domain. Each frame completion is pushed into a first-word-fall-through (FWFT) FIFO, which a consumer drains over a valid/ready interface. It also counts buffered bytes and flags sticky overflow when a frame arrives while the FIFO is full.

Parameters:
DEPTH, 8, number of byte entries; power of two, minimum 2
SYNC_STAGES, 2, flip-flops in the rx_done synchroniser; minimum 2

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
rx_data  input  8  byte from SPI slave; stable from rx_done rise until next frame begins
rx_done  input  1  SPI slave frame-complete level; asynchronous to clk
m_data  output  8  head-of-FIFO byte; valid when m_valid=1
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data this cycle
count  output  $clog2(DEPTH)+1  bytes currently buffered, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky: a frame was dropped because the FIFO was full
clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, async): synchroniser flops, edge-history flop, wr_ptr, rd_ptr and count go to 0; overflow goes to 0. Outputs: m_valid=0, full=0, count=0, overflow=0, m_data=8'h00. Memory contents are not reset.
- Synchroniser: rx_done passes through SYNC_STAGES flops (s[0]..s[N-1]). One extra history flop (s_d) follows them.
- Capture pulse: cap = s[N-1] & ~s_d. This gives one pulse per rising edge of rx_done. A level held high for many cycles yields exactly one capture.
- Capture latency: rx_done is first sampled high at edge E. cap is active during the cycle after edge E+SYNC_STAGES-1. The write occurs at edge E+SYNC_STAGES, and m_valid rises after that edge. With defaults, m_valid rises at E+2, i.e. 3 edges counting E.
- Write: on cap with no overflow condition, mem[wr_ptr] <= rx_data and wr_ptr increments modulo DEPTH.
- Read: pop = m_valid & m_ready. On pop, rd_ptr increments modulo DEPTH.
- m_data is mem[rd_ptr] read combinationally (FWFT). m_data is 8'h00 when empty.
- Pointer wrap: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally. count disambiguates full from empty.
- count update per cycle: +1 on write only, -1 on pop only, unchanged on both or neither.
- Full, cap and pop in the same cycle: pop frees a slot, so the write is accepted. count stays DEPTH and overflow is not set.
- Full, cap and no pop: the byte is dropped, overflow <= 1, and pointers and count are unchanged.
- Empty with cap: the write is accepted. Pop is impossible because m_valid=0, so m_ready is ignored.
- overflow: set by a dropped capture, cleared by clr_overflow. A set and a clear in the same cycle resolve to set (set wins).
- Mid-frame reset: all state clears immediately. After rst deassertion, rx_done is re-synchronised from scratch.
  - If rx_done is already high when rst releases, s_d is 0. The byte is therefore captured once after SYNC_STAGES edges. This is required behaviour.
- No combinational path from any input to any output, except m_data through the memory read mux.

Decomposition:
- Package spi_pkg holds:
  - SPI_DATA_W = 8
  - typedef logic [SPI_DATA_W-1:0] spi_byte_t, used for rx_data, m_data and memory entries
- One sub-module, spi_done_sync: SYNC_STAGES-deep synchroniser plus rising-edge detector.
  - Ports: clk, rst, async_in, sync_out, rise_pulse.
  - Reusable later for cs and other slave-side status into the system domain.
- FIFO storage, pointers, count and overflow logic live in spi_rx_buffer.

Test Plan:
- Single frame: rx_data=8'hA5, rx_done rises. Expect m_valid=1 exactly 3 clk edges after the first sample (SYNC_STAGES=2), m_data=8'hA5, count=1. Pulse m_ready for one cycle: m_valid=0, count=0.
- Held level: rx_done held high for 20 cycles with rx_data=8'h3C. Expect exactly one entry (count=1), then no further writes until rx_done falls and rises again.
- Fill and overflow: 8 frames 8'h01..8'h08 with m_ready=0. Expect full=1, count=8. A 9th frame 8'hFF gives overflow=1, count=8, and no FF stored. Drain: 01..08 in order.
- Wrap-around: 5 frames, pop 5, then 6 more frames 8'h10..8'h15. Expect pointers wrap, data exits 10..15 in order, count returns to 0.
- Simultaneous full+cap+pop: FIFO full with 01..08, cap (8'h09) in the same cycle as pop. Expect count stays 8, overflow stays 0, final drain order 02..09.
- Async reset mid-operation: 3 bytes buffered, overflow set, rst=0 asserted mid-cycle. Expect count=0, m_valid=0, overflow=0 immediately, without waiting for a clk edge. After release with rx_done still high, expect exactly one capture.
